// File: rtl/crc32_check_unit.sv
// crc32_check_unit: receive-side CRC-32 frame checker.
// Bytes stream through a 4-byte window; only bytes evicted from the window
// are folded into the CRC, so the trailing 4-byte FCS never enters it.
// The unit emits one registered verdict per frame.
module crc32_check_unit #(
  parameter logic [31:0] POLY   = 32'hEDB88320,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        recv_val,
  output logic        recv_rdy,
  input  logic [7:0]  recv_msg,
  input  logic        recv_last,
  output logic        send_val,
  input  logic        send_rdy,
  output logic [33:0] send_msg
);

  typedef enum logic {ACC, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] crc;
  logic [2:0]  fill;
  logic [7:0]  win [4];

  logic        recv_fire, send_fire;
  logic [31:0] crc_upd, crc_field, fcs;
  logic [2:0]  fill_upd;
  logic        runt;

  // Byte-wide unrolled reflected CRC update, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Handshake qualifiers and per-byte datapath values for the current byte.
  always_comb begin
    recv_rdy  = reset && (state == ACC);
    send_val  = (state == RESP);
    recv_fire = recv_val && recv_rdy;
    send_fire = send_val && send_rdy;
    crc_upd   = (fill == 3'd4) ? crc_byte(crc, win[0]) : crc;
    fill_upd  = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    crc_field = crc_upd ^ XOROUT;
    // Window contents after this byte shifts in; oldest byte is the FCS LSB.
    fcs       = {recv_msg, win[3], win[2], win[1]};
    runt      = (fill < 3'd3);
  end

  // Next-state logic: accept bytes until the last one, then hold the verdict.
  always_comb begin
    state_next = state;
    case (state)
      ACC:  if (recv_fire && recv_last) state_next = RESP;
      RESP: if (send_fire)              state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ACC;
    else        state <= state_next;
  end

  // Window shift, CRC fold, verdict capture and per-frame reinitialisation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc      <= INIT;
      fill     <= 3'd0;
      win[0]   <= 8'd0;
      win[1]   <= 8'd0;
      win[2]   <= 8'd0;
      win[3]   <= 8'd0;
      send_msg <= 34'd0;
    end else if (recv_fire) begin
      crc    <= crc_upd;
      fill   <= fill_upd;
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= win[3];
      win[3] <= recv_msg;
      if (recv_last) begin
        if (runt) send_msg <= {1'b1, 1'b0, 32'd0};
        else      send_msg <= {1'b0, (crc_field == fcs), crc_field};
      end
    end else if (send_fire) begin
      crc    <= INIT;
      fill   <= 3'd0;
      win[0] <= 8'd0;
      win[1] <= 8'd0;
      win[2] <= 8'd0;
      win[3] <= 8'd0;
    end
  end

endmodule
